// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: write-back source select, load sizes and
// special register numbers.
package mips_pkg;

  typedef enum logic [1:0] {
    MEMTOREG_ALU  = 2'd0,
    MEMTOREG_LOAD = 2'd1,
    MEMTOREG_LINK = 2'd2,
    MEMTOREG_RSVD = 2'd3
  } memtoreg_e;

  typedef enum logic [1:0] {
    LOAD_WORD = 2'd0,
    LOAD_HALF = 2'd1,
    LOAD_BYTE = 2'd2,
    LOAD_RSVD = 2'd3
  } load_size_e;

  // $k1, holds the UART condition flag in bit 0
  localparam int unsigned REG_K1 = 27;

endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB handshake and register-file write port bundle.
// The master modport is the MEM-stage side; the slave modport is wb_stage.
interface wb_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              in_valid;
  logic              stall;
  logic              flush;
  logic              in_reg_wr;
  logic [ADDR_W-1:0] in_reg_dst;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_mem_data;
  logic [DATA_W-1:0] in_pc_plus4;
  logic [1:0]        in_memtoreg;
  logic [1:0]        in_load_size;
  logic              in_load_signed;
  logic              uart_irq_req;
  logic              wr;
  logic [ADDR_W-1:0] addr3;
  logic [DATA_W-1:0] data3;
  logic              wb_valid;
  logic              uart;

  modport master (
    output in_valid, stall, flush, in_reg_wr, in_reg_dst, in_alu_result, in_mem_data,
           in_pc_plus4, in_memtoreg, in_load_size, in_load_signed, uart_irq_req,
    input  wr, addr3, data3, wb_valid, uart
  );

  modport slave (
    input  in_valid, stall, flush, in_reg_wr, in_reg_dst, in_alu_result, in_mem_data,
           in_pc_plus4, in_memtoreg, in_load_size, in_load_signed, uart_irq_req,
    output wr, addr3, data3, wb_valid, uart
  );
endinterface

// File: rtl/wb_stage_load_align.sv
// Combinational little-endian load alignment with zero/sign extension.
// Assumes DATA_W >= 32.
module load_align
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        off_i,
  input  logic [1:0]        size_i,
  input  logic              sign_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection and extension; off_i[0] is ignored for halfwords
  always_comb begin
    byte_sel = word_i[7:0];
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    data_o   = word_i;
    unique case (off_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
    endcase
    case (load_size_e'(size_i))
      LOAD_HALF: data_o = {{(DATA_W-16){sign_i & half_sel[15]}}, half_sel};
      LOAD_BYTE: data_o = {{(DATA_W-8){sign_i & byte_sel[7]}}, byte_sel};
      default:   data_o = word_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back select.
// Optional feature macro: UART_IRQ_LATCH_EN (sticky UART request that defers
// the uart strobe away from pipeline writes to $k1).
module wb_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input logic       clk,
  input logic       reset,
  wb_stage_if.slave bus
);

  logic              valid_q, valid_d;
  logic              reg_wr_q, reg_wr_d;
  logic [ADDR_W-1:0] addr3_q, addr3_d;
  logic [DATA_W-1:0] data3_q, data3_d;
  logic              committed_q, committed_d;
  logic              uart_q, uart_d;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] wb_data;
  logic              wr;

  load_align #(
    .DATA_W (DATA_W)
  ) u_load_align (
    .word_i (bus.in_mem_data),
    .off_i  (bus.in_alu_result[1:0]),
    .size_i (bus.in_load_size),
    .sign_i (bus.in_load_signed),
    .data_o (load_val)
  );

  // Write-back value is selected before the register, so data3 is a flop output
  always_comb begin
    wb_data = bus.in_alu_result;
    case (memtoreg_e'(bus.in_memtoreg))
      MEMTOREG_LOAD: wb_data = load_val;
      MEMTOREG_LINK: wb_data = bus.in_pc_plus4;
      default:       wb_data = bus.in_alu_result;
    endcase
  end

  // committed suppresses repeat writes while a retiring instruction is stalled
  assign wr = valid_q & reg_wr_q & (addr3_q != '0) & ~committed_q;

  // Pipeline register next state: capture, hold on stall, flush always wins
  always_comb begin
    valid_d     = valid_q;
    reg_wr_d    = reg_wr_q;
    addr3_d     = addr3_q;
    data3_d     = data3_q;
    committed_d = committed_q;
    if (!bus.stall) begin
      valid_d     = bus.in_valid & ~bus.flush;
      reg_wr_d    = bus.in_reg_wr;
      addr3_d     = bus.in_reg_dst;
      data3_d     = wb_data;
      committed_d = 1'b0;
    end else begin
      if (bus.flush) valid_d = 1'b0;
      if (wr) committed_d = 1'b1;
    end
  end

`ifdef UART_IRQ_LATCH_EN
  logic pending_q, pending_d;
  logic uart_fire;

  // Defer the strobe while WB is stalled or writing $k1; new requests re-arm
  always_comb begin
    uart_fire = pending_q & ~bus.stall & (~wr | (addr3_q != ADDR_W'(REG_K1)));
    uart_d    = uart_fire;
    pending_d = (pending_q & ~uart_fire) | bus.uart_irq_req;
  end

  // Pending request register
  always_ff @(posedge clk) begin
    if (!reset) pending_q <= 1'b0;
    else        pending_q <= pending_d;
  end
`else
  // Plain one-cycle registered copy of the request
  always_comb begin
    uart_d = bus.uart_irq_req;
  end
`endif

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      reg_wr_q    <= 1'b0;
      addr3_q     <= '0;
      data3_q     <= '0;
      committed_q <= 1'b0;
      uart_q      <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      reg_wr_q    <= reg_wr_d;
      addr3_q     <= addr3_d;
      data3_q     <= data3_d;
      committed_q <= committed_d;
      uart_q      <= uart_d;
    end
  end

  assign bus.wr       = wr;
  assign bus.addr3    = addr3_q;
  assign bus.data3    = data3_q;
  assign bus.wb_valid = valid_q;
  assign bus.uart     = uart_q;

endmodule
